// File: rtl/tetris_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tetris_game_ctrl
// Brief    : Main game sequencer: board reset, spawn, fall, land, clear,
//            pause and game-over, plus gravity timer and line/level counters.
// Revision : 1.0 - initial release
// ============================================================================
module tetris_game_ctrl #(
    parameter int TICK_W          = 20,
    parameter int BASE_PERIOD     = 1000000,
    parameter int PERIOD_STEP     = 50000,
    parameter int MIN_PERIOD      = 50000,
    parameter int LINES_PER_LEVEL = 10,
    parameter int LEVEL_W         = 4,
    parameter int LEVEL_MAX       = 15,
    parameter int LINES_W         = 12
) (
    input  logic               clka,
    input  logic               restart_n,
    input  logic               start,
    input  logic               pause,
    input  logic               gen_done,
    input  logic               game_over,
    input  logic               placed,
    input  logic               clear_done,
    input  logic [2:0]         rows_cleared,
    output logic [2:0]         state,
    output logic [2:0]         old_state,
    output logic               board_clr,
    output logic               gen_req,
    output logic               clear_req,
    output logic               drop_tick,
    output logic [LEVEL_W-1:0] level,
    output logic [LINES_W-1:0] lines
);

    localparam logic [2:0] c_ST_GEN      = 3'b000;
    localparam logic [2:0] c_ST_MOVE     = 3'b001;
    localparam logic [2:0] c_ST_LAND     = 3'b010;
    localparam logic [2:0] c_ST_CLEAR    = 3'b011;
    localparam logic [2:0] c_ST_NEWBOARD = 3'b100;
    localparam logic [2:0] c_ST_GAMEOVER = 3'b101;
    localparam logic [2:0] c_ST_PAUSE    = 3'b110;

    // Sized to hold LINES_PER_LEVEL-1 plus a maximal 4-row clear
    localparam int c_LIL_W  = $clog2(LINES_PER_LEVEL + 4);
    localparam int c_LSUM_W = LINES_W + 1;

    localparam logic [63:0]          c_BASE      = 64'(BASE_PERIOD);
    localparam logic [63:0]          c_STEP      = 64'(PERIOD_STEP);
    localparam logic [63:0]          c_MIN       = 64'(MIN_PERIOD);
    localparam logic [c_LIL_W-1:0]   c_LPL       = c_LIL_W'(LINES_PER_LEVEL);
    localparam logic [LEVEL_W-1:0]   c_LEVEL_MAX = LEVEL_W'(LEVEL_MAX);
    localparam logic [LEVEL_W-1:0]   c_LEVEL_ONE = LEVEL_W'(1);
    localparam logic [TICK_W-1:0]    c_TICK_ONE  = TICK_W'(1);

    logic [2:0]         r_state;
    logic [2:0]         r_old_state;
    logic [2:0]         w_next_state;
    logic [TICK_W-1:0]  r_tick_cnt;
    logic [LEVEL_W-1:0] r_level;
    logic [LINES_W-1:0] r_lines;
    logic [c_LIL_W-1:0] r_lines_in_level;

    logic [63:0]         w_step_total;
    logic [63:0]         w_period;
    logic                w_tick_hit;
    logic [2:0]          w_rows_eff;
    logic [c_LSUM_W-1:0] w_lines_sum;
    logic [LINES_W-1:0]  w_lines_next;
    logic [c_LIL_W-1:0]  w_lil_sum;
    logic                w_level_up;
    logic [c_LIL_W-1:0]  w_lil_next;
    logic [LEVEL_W-1:0]  w_level_next;

    // Period arithmetic is done in 64 bits so the subtraction cannot wrap
    always_comb begin
        w_step_total = 64'(r_level) * c_STEP;
        if (c_BASE > w_step_total + c_MIN) begin
            w_period = c_BASE - w_step_total;
        end else begin
            w_period = c_MIN;
        end
        w_tick_hit = (64'(r_tick_cnt) == (w_period - 64'd1));
    end

    always_comb begin
        w_rows_eff   = (rows_cleared > 3'd4) ? 3'd4 : rows_cleared;
        w_lines_sum  = c_LSUM_W'(r_lines) + c_LSUM_W'(w_rows_eff);
        w_lines_next = w_lines_sum[LINES_W] ? '1 : w_lines_sum[LINES_W-1:0];
        w_lil_sum    = r_lines_in_level + c_LIL_W'(w_rows_eff);
        w_level_up   = (w_lil_sum >= c_LPL);
        w_lil_next   = w_level_up ? (w_lil_sum - c_LPL) : w_lil_sum;
        w_level_next = (w_level_up && (r_level != c_LEVEL_MAX)) ?
                       (r_level + c_LEVEL_ONE) : r_level;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_NEWBOARD: w_next_state = c_ST_GEN;
            c_ST_GEN: begin
                if (gen_done) begin
                    w_next_state = game_over ? c_ST_GAMEOVER : c_ST_MOVE;
                end
            end
            c_ST_MOVE: begin
                if (game_over) begin
                    w_next_state = c_ST_GAMEOVER;
                end else if (placed) begin
                    w_next_state = c_ST_LAND;
                end else if (pause) begin
                    w_next_state = c_ST_PAUSE;
                end
            end
            c_ST_PAUSE: begin
                if (!pause) begin
                    w_next_state = c_ST_MOVE;
                end
            end
            c_ST_LAND:  w_next_state = game_over ? c_ST_GAMEOVER : c_ST_CLEAR;
            c_ST_CLEAR: begin
                if (clear_done) begin
                    w_next_state = c_ST_GEN;
                end
            end
            c_ST_GAMEOVER: begin
                if (start) begin
                    w_next_state = c_ST_NEWBOARD;
                end
            end
            default: w_next_state = c_ST_NEWBOARD;
        endcase
    end

    always_ff @(posedge clka) begin
        if (!restart_n) begin
            r_state     <= c_ST_NEWBOARD;
            r_old_state <= c_ST_NEWBOARD;
        end else begin
            r_old_state <= r_state;
            r_state     <= w_next_state;
        end
    end

    // Tick counter restarts in LAND so a shorter post-level-up period is safe
    always_ff @(posedge clka) begin
        if (!restart_n || (r_state == c_ST_NEWBOARD)) begin
            r_tick_cnt       <= '0;
            r_level          <= '0;
            r_lines          <= '0;
            r_lines_in_level <= '0;
        end else begin
            case (r_state)
                c_ST_MOVE: r_tick_cnt <= w_tick_hit ? '0 : (r_tick_cnt + c_TICK_ONE);
                c_ST_LAND: r_tick_cnt <= '0;
                c_ST_CLEAR: begin
                    if (clear_done) begin
                        r_lines          <= w_lines_next;
                        r_lines_in_level <= w_lil_next;
                        r_level          <= w_level_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign state     = r_state;
    assign old_state = r_old_state;
    assign board_clr = (r_state == c_ST_NEWBOARD);
    assign gen_req   = (r_state == c_ST_GEN);
    assign clear_req = (r_state == c_ST_CLEAR);
    assign drop_tick = (r_state == c_ST_MOVE) && w_tick_hit;
    assign level     = r_level;
    assign lines     = r_lines;

endmodule
`default_nettype wire

// File: tb/tb_tetris_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_tetris_game_ctrl
// Brief    : Directed self-checking bench for tetris_game_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tetris_game_ctrl;

    localparam int TICK_W          = 8;
    localparam int BASE_PERIOD     = 8;
    localparam int PERIOD_STEP     = 3;
    localparam int MIN_PERIOD      = 4;
    localparam int LINES_PER_LEVEL = 10;
    localparam int LEVEL_W         = 2;
    localparam int LEVEL_MAX       = 2;
    localparam int LINES_W         = 5;

    localparam int c_GEN = 0, c_MOVE = 1, c_LAND = 2, c_CLEAR = 3;
    localparam int c_NEWBOARD = 4, c_GAMEOVER = 5, c_PAUSE = 6;

    logic               clka = 1'b0;
    logic               restart_n = 1'b0;
    logic               start = 1'b0;
    logic               pause = 1'b0;
    logic               gen_done = 1'b0;
    logic               game_over = 1'b0;
    logic               placed = 1'b0;
    logic               clear_done = 1'b0;
    logic [2:0]         rows_cleared = 3'd0;
    logic [2:0]         state;
    logic [2:0]         old_state;
    logic               board_clr;
    logic               gen_req;
    logic               clear_req;
    logic               drop_tick;
    logic [LEVEL_W-1:0] level;
    logic [LINES_W-1:0] lines;

    int n_checks = 0;
    int n_fail   = 0;

    tetris_game_ctrl #(
        .TICK_W          (TICK_W),
        .BASE_PERIOD     (BASE_PERIOD),
        .PERIOD_STEP     (PERIOD_STEP),
        .MIN_PERIOD      (MIN_PERIOD),
        .LINES_PER_LEVEL (LINES_PER_LEVEL),
        .LEVEL_W         (LEVEL_W),
        .LEVEL_MAX       (LEVEL_MAX),
        .LINES_W         (LINES_W)
    ) dut (
        .clka         (clka),
        .restart_n    (restart_n),
        .start        (start),
        .pause        (pause),
        .gen_done     (gen_done),
        .game_over    (game_over),
        .placed       (placed),
        .clear_done   (clear_done),
        .rows_cleared (rows_cleared),
        .state        (state),
        .old_state    (old_state),
        .board_clr    (board_clr),
        .gen_req      (gen_req),
        .clear_req    (clear_req),
        .drop_tick    (drop_tick),
        .level        (level),
        .lines        (lines)
    );

    always #5 clka = ~clka;

    task automatic check_eq(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clka);
        #1;
    endtask

    // From GEN: spawn, land immediately, end up in CLEAR
    task automatic piece_to_clear();
        gen_done = 1'b1;
        step();
        gen_done = 1'b0;
        placed = 1'b1;
        step();
        placed = 1'b0;
        step();
    endtask

    task automatic do_clear(input int rows);
        rows_cleared = 3'(rows);
        clear_done = 1'b1;
        step();
        clear_done = 1'b0;
        rows_cleared = 3'd0;
    endtask

    // From GEN: spawn, expect the first drop on MOVE cycle 'period', place on it
    task automatic fall_check(input int period, input string tag);
        gen_done = 1'b1;
        step();
        gen_done = 1'b0;
        for (int k = 1; k <= period; k++) begin
            check_eq(tag, int'(drop_tick), (k == period) ? 1 : 0);
            if (k == period) placed = 1'b1;
            step();
        end
        placed = 1'b0;
        check_eq({tag, "_land"}, int'(state), c_LAND);
        step();
    endtask

    initial begin
        // Reset
        step();
        step();
        check_eq("rst_state", int'(state), c_NEWBOARD);
        check_eq("rst_old", int'(old_state), c_NEWBOARD);
        check_eq("rst_bclr", int'(board_clr), 1);
        check_eq("rst_genreq", int'(gen_req), 0);
        check_eq("rst_clrreq", int'(clear_req), 0);
        check_eq("rst_drop", int'(drop_tick), 0);
        check_eq("rst_level", int'(level), 0);
        check_eq("rst_lines", int'(lines), 0);

        restart_n = 1'b1;
        step();
        check_eq("gen_state", int'(state), c_GEN);
        check_eq("gen_old", int'(old_state), c_NEWBOARD);
        check_eq("gen_bclr", int'(board_clr), 0);
        check_eq("gen_req", int'(gen_req), 1);
        step();
        check_eq("gen_hold", int'(state), c_GEN);

        gen_done = 1'b1;
        step();
        gen_done = 1'b0;
        check_eq("move_state", int'(state), c_MOVE);
        check_eq("move_genreq", int'(gen_req), 0);

        // Period 8 at level 0: ticks on MOVE cycles 8 and 16
        for (int c = 1; c <= 18; c++) begin
            check_eq("grav0", int'(drop_tick), (c == 8 || c == 16) ? 1 : 0);
            step();
        end
        // Cycle 19, counter 2; PAUSE is entered with the counter at 3
        pause = 1'b1;
        step();
        check_eq("pause_state", int'(state), c_PAUSE);
        check_eq("pause_drop", int'(drop_tick), 0);
        game_over = 1'b1;
        step();
        game_over = 1'b0;
        check_eq("pause_ignore_go", int'(state), c_PAUSE);
        repeat (8) step();
        check_eq("pause_held", int'(state), c_PAUSE);
        pause = 1'b0;
        step();
        check_eq("resume_state", int'(state), c_MOVE);
        for (int r = 1; r <= 6; r++) begin
            check_eq("resume_drop", int'(drop_tick), (r == 5) ? 1 : 0);
            if (r < 6) step();
        end

        // placed and pause together: placed wins
        placed = 1'b1;
        pause = 1'b1;
        step();
        placed = 1'b0;
        pause = 1'b0;
        check_eq("pl_pause_land", int'(state), c_LAND);
        check_eq("land_old", int'(old_state), c_MOVE);
        step();
        check_eq("clear_state", int'(state), c_CLEAR);
        check_eq("clear_req", int'(clear_req), 1);

        // Stray gen_done in CLEAR is ignored
        gen_done = 1'b1;
        step();
        gen_done = 1'b0;
        check_eq("stray_gen", int'(state), c_CLEAR);

        do_clear(4);
        check_eq("c1_state", int'(state), c_GEN);
        check_eq("c1_old", int'(old_state), c_CLEAR);
        check_eq("c1_clrreq", int'(clear_req), 0);
        check_eq("c1_lines", int'(lines), 4);
        check_eq("c1_level", int'(level), 0);
        piece_to_clear();
        do_clear(4);
        check_eq("c2_lines", int'(lines), 8);
        check_eq("c2_level", int'(level), 0);
        piece_to_clear();
        do_clear(3);
        check_eq("c3_lines", int'(lines), 11);
        check_eq("c3_level", int'(level), 1);

        // Level 1: period max(8-3,4) = 5; drop coincident with placed
        fall_check(5, "grav1");
        do_clear(7);
        check_eq("c7_lines", int'(lines), 15);
        check_eq("c7_level", int'(level), 1);
        piece_to_clear();
        do_clear(4);
        check_eq("c5_lines", int'(lines), 19);
        check_eq("c5_level", int'(level), 1);
        piece_to_clear();
        do_clear(1);
        check_eq("c6_lines", int'(lines), 20);
        check_eq("c6_level", int'(level), 2);

        // Level 2: 8-6 = 2 is floored to MIN_PERIOD = 4
        fall_check(4, "grav2");
        do_clear(4);
        piece_to_clear();
        do_clear(4);
        check_eq("c8_lines", int'(lines), 28);
        piece_to_clear();
        do_clear(4);
        check_eq("sat_lines", int'(lines), 31);
        check_eq("sat_level", int'(level), 2);
        piece_to_clear();
        do_clear(4);
        check_eq("sat_lines2", int'(lines), 31);

        // Top-out on spawn
        gen_done = 1'b1;
        game_over = 1'b1;
        step();
        gen_done = 1'b0;
        game_over = 1'b0;
        check_eq("go_state", int'(state), c_GAMEOVER);
        check_eq("go_genreq", int'(gen_req), 0);
        check_eq("go_clrreq", int'(clear_req), 0);
        check_eq("go_bclr", int'(board_clr), 0);
        step();
        check_eq("go_hold", int'(state), c_GAMEOVER);
        check_eq("go_lines_hold", int'(lines), 31);
        start = 1'b1;
        step();
        start = 1'b0;
        check_eq("st_newboard", int'(state), c_NEWBOARD);
        check_eq("st_bclr", int'(board_clr), 1);
        step();
        check_eq("st_gen", int'(state), c_GEN);
        check_eq("st_bclr_off", int'(board_clr), 0);
        check_eq("st_lines", int'(lines), 0);
        check_eq("st_level", int'(level), 0);

        // placed and game_over together in MOVE
        gen_done = 1'b1;
        step();
        gen_done = 1'b0;
        placed = 1'b1;
        game_over = 1'b1;
        step();
        placed = 1'b0;
        game_over = 1'b0;
        check_eq("pl_go", int'(state), c_GAMEOVER);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        check_eq("restart_gen", int'(state), c_GEN);

        // Reset in the middle of a clear handshake
        piece_to_clear();
        do_clear(2);
        check_eq("mid_lines_pre", int'(lines), 2);
        piece_to_clear();
        check_eq("mid_clrreq", int'(clear_req), 1);
        restart_n = 1'b0;
        step();
        check_eq("mid_state", int'(state), c_NEWBOARD);
        check_eq("mid_clrreq_off", int'(clear_req), 0);
        check_eq("mid_lines", int'(lines), 0);
        restart_n = 1'b1;
        rows_cleared = 3'd4;
        clear_done = 1'b1;
        step();
        clear_done = 1'b0;
        rows_cleared = 3'd0;
        check_eq("stale_state", int'(state), c_GEN);
        check_eq("stale_lines", int'(lines), 0);
        step();
        check_eq("stale_hold", int'(state), c_GEN);
        check_eq("stale_lines2", int'(lines), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
